mem_lsu: RTL and testbench

- Memory-stage load/store unit directly downstream of the EX/MEM pipeline register.
- Takes the registered address, store data, funct3 and memread/memwrite strobes, and runs a request/acknowledge transaction on the data-memory bus.
- Holds the whole pipeline via o_stall until the access completes.
- Returns aligned, sign/zero-extended load data to writeback; detects misaligned and illegal accesses.

---
 rtl/mem_lsu.sv | 204 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: request/ack data-bus access with pipeline stall,
// store lane steering and load extension. Optional ack timeout under `LSU_TIMEOUT_EN`.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_flush,
    input  logic        i_memread,
    input  logic        i_memwrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_err,
    output logic [1:0]  o_err_cause
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("mem_lsu: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state;
    logic        kill;
    logic        op_load;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;

    logic        mem_op_c;
    logic        legal_c;
    logic        aligned_c;
    logic        issue_c;
    logic [31:0] st_wdata_c;
    logic [3:0]  st_be_c;
    logic [7:0]  sel_byte_c;
    logic [15:0] sel_half_c;
    logic [31:0] load_ext_c;
    logic        tmo_hit_c;

    // Decode legality and natural alignment of the op sitting in EX/MEM.
    always_comb begin
        mem_op_c  = i_valid & (i_memread | i_memwrite) & ~i_flush;
        legal_c   = 1'b0;
        aligned_c = 1'b1;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = ~i_memwrite;
            default:                legal_c = 1'b0;
        endcase
        case (i_funct3[1:0])
            2'b01:   aligned_c = ~i_addr[0];
            2'b10:   aligned_c = (i_addr[1:0] == 2'b00);
            default: aligned_c = 1'b1;
        endcase
        issue_c = mem_op_c & legal_c & aligned_c;
    end

    // Replicate store data across lanes; loads request the full word.
    always_comb begin
        st_wdata_c = i_wdata;
        st_be_c    = 4'b1111;
        if (i_memwrite) begin
            case (i_funct3[1:0])
                2'b00: begin
                    st_wdata_c = {4{i_wdata[7:0]}};
                    st_be_c    = 4'b0001 << i_addr[1:0];
                end
                2'b01: begin
                    st_wdata_c = {2{i_wdata[15:0]}};
                    st_be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata_c = i_wdata;
                    st_be_c    = 4'b1111;
                end
            endcase
        end
    end

    // Pick the addressed byte/half from the returned word and extend it.
    always_comb begin
        sel_byte_c = i_mem_rdata[{op_off, 3'b000} +: 8];
        sel_half_c = i_mem_rdata[{op_off[1], 4'b0000} +: 16];
        case (op_f3)
            3'b000:  load_ext_c = {{24{sel_byte_c[7]}}, sel_byte_c};
            3'b001:  load_ext_c = {{16{sel_half_c[15]}}, sel_half_c};
            3'b100:  load_ext_c = {24'h000000, sel_byte_c};
            3'b101:  load_ext_c = {16'h0000, sel_half_c};
            default: load_ext_c = i_mem_rdata;
        endcase
    end

    assign o_stall = ((state == ST_IDLE) & issue_c) | (state == ST_REQ);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts REQ cycles without ack; the last one before the limit triggers the abort.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo_cnt <= '0;
        end else if ((state == ST_IDLE) && issue_c) begin
            tmo_cnt <= '0;
        end else if ((state == ST_REQ) && !i_mem_ack) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo_hit_c = (state == ST_REQ) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Transaction FSM with registered bus, completion and error outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            kill        <= 1'b0;
            op_load     <= 1'b0;
            op_f3       <= 3'b000;
            op_off      <= 2'b00;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
            o_done      <= 1'b0;
            o_load_data <= '0;
            o_err       <= 1'b0;
            o_err_cause <= 2'b00;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    kill <= 1'b0;
                    if (issue_c) begin
                        state       <= ST_REQ;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_memwrite;
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_wdata <= st_wdata_c;
                        o_mem_be    <= st_be_c;
                        op_load     <= ~i_memwrite;
                        op_f3       <= i_funct3;
                        op_off      <= i_addr[1:0];
                    end else if (mem_op_c) begin
                        o_err       <= 1'b1;
                        o_err_cause <= legal_c ? CAUSE_MISALIGN : CAUSE_ILLEGAL;
                    end
                end
                ST_REQ: begin
                    if (i_flush) begin
                        kill <= 1'b1;
                    end
                    if (i_mem_ack) begin
                        state     <= ST_DONE;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_done    <= ~(kill | i_flush);
                        if (op_load && !kill && !i_flush) begin
                            o_load_data <= load_ext_c;
                        end
                    end else if (tmo_hit_c) begin
                        state       <= ST_DONE;
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_err       <= 1'b1;
                        o_err_cause <= CAUSE_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: completions and error pulses are matched against
// expectations queued when each access is driven.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_flush, i_memread, i_memwrite;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_err;
    logic [1:0]  o_err_cause;

    mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_valid(i_valid), .i_flush(i_flush),
        .i_memread(i_memread), .i_memwrite(i_memwrite),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_done(o_done), .o_load_data(o_load_data),
        .o_err(o_err), .o_err_cause(o_err_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [1:0]  cause;
        logic [31:0] ld;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_ld = 32'h0;

    int          st, rq;
    logic [3:0]  be_o;
    logic [31:0] wd_o, ad_o;
    logic        we_o;

    function automatic exp_t mk_done(input logic [31:0] ld);
        exp_t e;
        e.is_err = 1'b0; e.cause = 2'b00; e.ld = ld;
        return e;
    endfunction

    function automatic exp_t mk_err(input logic [1:0] cause);
        exp_t e;
        e.is_err = 1'b1; e.cause = cause; e.ld = 32'h0;
        return e;
    endfunction

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (8 * off);
        case (f3)
            3'b000:  return s[7]  ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
            3'b001:  return s[15] ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
            3'b100:  return s & 32'h0000_00FF;
            3'b101:  return s & 32'h0000_FFFF;
            default: return rd;
        endcase
    endfunction

    // Completion/error monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (o_done || o_err)) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected done=%0b err=%0b cause=%b t=%0t", o_done, o_err, o_err_cause, $time);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_err) begin
                    if (o_err !== 1'b1 || o_done !== 1'b0 || o_err_cause !== mon_e.cause) begin
                        n_fail++;
                        $display("FAIL sb_err got err=%b done=%b cause=%b want cause=%b t=%0t",
                                 o_err, o_done, o_err_cause, mon_e.cause, $time);
                    end
                end else if (o_done !== 1'b1 || o_err !== 1'b0 || o_load_data !== mon_e.ld) begin
                    n_fail++;
                    $display("FAIL sb_done got done=%b err=%b load=%h want load=%h t=%0t",
                             o_done, o_err, o_load_data, mon_e.ld, $time);
                end
            end
        end
    end

    // Drive one access starting at the current negedge; ack after `waits` REQ cycles.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int waits,
                          input logic [31:0] rdata, input int flush_req,
                          output int stalls, output int req_cycles, output logic [3:0] be,
                          output logic [31:0] mwd, output logic [31:0] maddr, output logic we);
        bit fin;
        i_valid = 1'b1; i_memread = rd; i_memwrite = wr;
        i_funct3 = f3; i_addr = addr; i_wdata = wd;
        stalls = 0; req_cycles = 0; be = '0; mwd = '0; maddr = '0; we = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            #1;
            if (o_stall) stalls++;
            else fin = 1'b1;
            i_mem_ack = 1'b0;
            i_flush   = 1'b0;
            if (o_mem_req) begin
                if (req_cycles == 0) begin
                    be = o_mem_be; mwd = o_mem_wdata; maddr = o_mem_addr; we = o_mem_we;
                end
                i_mem_ack   = (req_cycles == waits);
                i_mem_rdata = rdata;
                i_flush     = (req_cycles == flush_req);
                req_cycles++;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL run_op_bound stall never released addr=%h", addr);
        end
        @(negedge clk);
        i_valid = 1'b0; i_memread = 1'b0; i_memwrite = 1'b0;
        i_mem_ack = 1'b0; i_flush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (o_mem_req !== 1'b0)   begin n_fail++; $display("FAIL rst_req got %b want 0", o_mem_req); end
        n_checks++; if (o_stall !== 1'b0)     begin n_fail++; $display("FAIL rst_stall got %b want 0", o_stall); end
        n_checks++; if (o_done !== 1'b0 || o_err !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got done=%b err=%b want 0", o_done, o_err); end
        n_checks++; if (o_load_data !== 32'h0) begin n_fail++; $display("FAIL rst_load got %h want 0", o_load_data); end
        n_checks++; if (o_mem_be !== 4'h0 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0)
            begin n_fail++; $display("FAIL rst_bus got be=%h addr=%h wd=%h want 0", o_mem_be, o_mem_addr, o_mem_wdata); end
        n_checks++; if (o_err_cause !== 2'b00 || o_mem_we !== 1'b0)
            begin n_fail++; $display("FAIL rst_cause got cause=%b we=%b want 0", o_err_cause, o_mem_we); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_word;
        sb_q.push_back(mk_done(32'hDEAD_BEEF));
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, -1, st, rq, be_o, wd_o, ad_o, we_o);
        model_ld = 32'hDEAD_BEEF;
        n_checks++; if (st !== 2)  begin n_fail++; $display("FAIL lw_stall got %0d want 2", st); end
        n_checks++; if (rq !== 1)  begin n_fail++; $display("FAIL lw_req got %0d want 1", rq); end
        n_checks++; if (be_o !== 4'hF || we_o !== 1'b0 || ad_o !== 32'h100)
            begin n_fail++; $display("FAIL lw_bus got be=%h we=%b addr=%h want f 0 100", be_o, we_o, ad_o); end
    endtask

    task automatic test_load_extend;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] ads  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(mk_done(exps[i]));
            run_op(1'b1, 1'b0, f3s[i], ads[i], 32'h0, 0, 32'h80FF_0000, -1, st, rq, be_o, wd_o, ad_o, we_o);
            model_ld = exps[i];
            n_checks++; if (be_o !== 4'hF || ad_o !== 32'h100)
                begin n_fail++; $display("FAIL ext_bus[%0d] got be=%h addr=%h want f 100", i, be_o, ad_o); end
        end
    endtask

    task automatic test_store;
        sb_q.push_back(mk_done(model_ld));
        run_op(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 3, 32'h0, -1, st, rq, be_o, wd_o, ad_o, we_o);
        n_checks++; if (we_o !== 1'b1 || be_o !== 4'b1100 || wd_o !== 32'hABCD_ABCD || ad_o !== 32'h204)
            begin n_fail++; $display("FAIL sh_bus got we=%b be=%b wd=%h addr=%h want 1 1100 abcdabcd 204", we_o, be_o, wd_o, ad_o); end
        n_checks++; if (st !== 5) begin n_fail++; $display("FAIL sh_stall got %0d want 5", st); end
        sb_q.push_back(mk_done(model_ld));
        run_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00EF, 0, 32'h0, -1, st, rq, be_o, wd_o, ad_o, we_o);
        n_checks++; if (be_o !== 4'b0010 || wd_o !== 32'hEFEF_EFEF || ad_o !== 32'h200)
            begin n_fail++; $display("FAIL sb_bus got be=%b wd=%h addr=%h want 0010 efefefef 200", be_o, wd_o, ad_o); end
        sb_q.push_back(mk_done(model_ld));
        run_op(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'h0, -1, st, rq, be_o, wd_o, ad_o, we_o);
        n_checks++; if (be_o !== 4'hF || wd_o !== 32'hCAFE_F00D || st !== 3)
            begin n_fail++; $display("FAIL sw_bus got be=%h wd=%h stall=%0d want f cafef00d 3", be_o, wd_o, st); end
    endtask

    task automatic test_errors;
        logic        rds [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [6] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b011, 3'b001};
        logic [31:0] ads [6] = '{32'h101, 32'h100, 32'h203, 32'h100, 32'h101, 32'h101};
        logic [1:0]  cs  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(mk_err(cs[i]));
            run_op(rds[i], ~rds[i], f3s[i], ads[i], 32'h55, 0, 32'h0, -1, st, rq, be_o, wd_o, ad_o, we_o);
            n_checks++; if (st !== 0 || rq !== 0)
                begin n_fail++; $display("FAIL err_noreq[%0d] got stall=%0d req=%0d want 0 0", i, st, rq); end
        end
    endtask

    task automatic test_flush;
        i_valid = 1'b1; i_memread = 1'b1; i_funct3 = 3'b010; i_addr = 32'h101; i_flush = 1'b1;
        #1;
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %b want 0", o_stall); end
        @(negedge clk);
        i_addr = 32'h100;
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL flush_idle_err got %b want 0", o_err); end
        @(negedge clk);
        n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_req got %b want 0", o_mem_req); end
        i_valid = 1'b0; i_memread = 1'b0; i_flush = 1'b0;
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'h1111_1111, 0, st, rq, be_o, wd_o, ad_o, we_o);
        n_checks++; if (rq !== 3 || st !== 4) begin n_fail++; $display("FAIL flush_req_hold got req=%0d stall=%0d want 3 4", rq, st); end
        n_checks++; if (o_load_data !== model_ld) begin n_fail++; $display("FAIL flush_load got %h want %h", o_load_data, model_ld); end
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h2222_2222, 0, st, rq, be_o, wd_o, ad_o, we_o);
        n_checks++; if (o_load_data !== model_ld || rq !== 1)
            begin n_fail++; $display("FAIL flush_ack_load got %h req=%0d want %h 1", o_load_data, rq, model_ld); end
    endtask

    task automatic test_ack_idle;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h3333_3333;
        repeat (2) @(negedge clk);
        i_mem_ack = 1'b0;
        n_checks++; if (o_done !== 1'b0 || o_stall !== 1'b0 || o_load_data !== model_ld)
            begin n_fail++; $display("FAIL ack_idle got done=%b stall=%b load=%h want 0 0 %h", o_done, o_stall, o_load_data, model_ld); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  kinds [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rd, ex;
        int          w;
        for (int i = 0; i < 8; i++) begin
            f3 = kinds[$urandom_range(0, 4)];
            off = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            rd = $urandom;
            w  = $urandom_range(0, 2);
            ex = ext_model(f3, off, rd);
            sb_q.push_back(mk_done(ex));
            run_op(1'b1, 1'b0, f3, {28'h000_0040, 2'b00, off}, 32'h0, w, rd, -1, st, rq, be_o, wd_o, ad_o, we_o);
            model_ld = ex;
            n_checks++; if (st !== 2 + w)
                begin n_fail++; $display("FAIL b2b_stall[%0d] got %0d want %0d", i, st, 2 + w); end
        end
    endtask

    task automatic test_async_reset;
        i_valid = 1'b1; i_memread = 1'b1; i_funct3 = 3'b010; i_addr = 32'h400;
        @(negedge clk);
        n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL arst_pre_req got %b want 1", o_mem_req); end
        #2;
        rst = 1'b1; i_valid = 1'b0; i_memread = 1'b0;
        #1;
        n_checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0)
            begin n_fail++; $display("FAIL arst_drop got req=%b stall=%b want 0 0", o_mem_req, o_stall); end
        @(negedge clk);
        rst = 1'b0;
        model_ld = 32'h0;
        n_checks++; if (o_load_data !== 32'h0) begin n_fail++; $display("FAIL arst_load got %h want 0", o_load_data); end
        sb_q.push_back(mk_done(32'h0000_0077));
        run_op(1'b1, 1'b0, 3'b100, 32'h401, 32'h0, 0, 32'h1234_7700, -1, st, rq, be_o, wd_o, ad_o, we_o);
        model_ld = 32'h0000_0077;
        n_checks++; if (st !== 2) begin n_fail++; $display("FAIL arst_recover got stall=%0d want 2", st); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout;
        sb_q.push_back(mk_err(2'b11));
        run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1000, 32'h0, -1, st, rq, be_o, wd_o, ad_o, we_o);
        n_checks++; if (rq !== 4 || st !== 5)
            begin n_fail++; $display("FAIL tmo_len got req=%0d stall=%0d want 4 5", rq, st); end
        n_checks++; if (o_load_data !== model_ld)
            begin n_fail++; $display("FAIL tmo_load got %h want %h", o_load_data, model_ld); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        i_valid = 1'b0; i_flush = 1'b0; i_memread = 1'b0; i_memwrite = 1'b0;
        i_funct3 = 3'b000; i_addr = 32'h0; i_wdata = 32'h0;
        i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_errors();
        test_flush();
        test_ack_idle();
        test_back_to_back();
        test_async_reset();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
